// File: rtl/ball_collision_gen2_pkg.sv
// Shared pong definitions: collision codes, collision FSM state encoding and
// a small helper that tells the FSM whether a code ends the rally.
package ball_collision_gen2_pkg;

   localparam logic [2:0] COL_NONE    = 3'd0;
   localparam logic [2:0] COL_RPADDLE = 3'd1;
   localparam logic [2:0] COL_FLOOR   = 3'd2;
   localparam logic [2:0] COL_CEILING = 3'd3;
   localparam logic [2:0] COL_RMISS   = 3'd4;
   localparam logic [2:0] COL_LMISS   = 3'd5;
   localparam logic [2:0] COL_LPADDLE = 3'd6;

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_HOLD   = 2'd1,
      ST_SCORED = 2'd2
   } state_e;

   function automatic logic is_miss(input logic [2:0] code);
      return (code == COL_RMISS) || (code == COL_LMISS);
   endfunction

endpackage

// File: rtl/ball_collision_gen2_collision_classifier.sv
// Combinational priority classifier for ball/field/paddle contact, plus the
// paddle hit-zone computed with constant threshold comparators.
module collision_classifier
   import ball_collision_gen2_pkg::*;
#(
   parameter int W          = 10,
   parameter int BALL_SIZE  = 8,
   parameter int PADDLE_LEN = 80,
   parameter int TOP        = 73,
   parameter int BOTTOM     = 472,
   parameter int LEFT       = 8,
   parameter int RIGHT      = 600,
   parameter int PADDLE_W   = 8,
   parameter int PLAYERS    = 1,
   parameter int ZONES      = 4
) (
   input  logic [W-1:0]               ball_x_i,
   input  logic [W-1:0]               ball_y_i,
   input  logic [W-1:0]               paddle_r_y_i,
   input  logic [W-1:0]               paddle_l_y_i,
   output logic [2:0]                 code_o,
   output logic [$clog2(ZONES)-1:0]   zone_o
);

   localparam int ZW  = $clog2(ZONES);
   localparam int SEG = (PADDLE_LEN + BALL_SIZE) / ZONES;

   localparam logic [W:0] BS_C     = (W+1)'(BALL_SIZE);
   localparam logic [W:0] PLEN_C   = (W+1)'(PADDLE_LEN);
   localparam logic [W:0] TOP_C    = (W+1)'(TOP);
   localparam logic [W:0] BOTTOM_C = (W+1)'(BOTTOM);
   localparam logic [W:0] LEFT_C   = (W+1)'(LEFT);
   localparam logic [W:0] RIGHT_C  = (W+1)'(RIGHT);
   localparam logic [W:0] RP_LO_C  = (W+1)'(RIGHT - PADDLE_W);
   localparam logic [W:0] RP_HI_C  = (W+1)'(RIGHT - 1);
   localparam logic [W:0] LP_LO_C  = (W+1)'(LEFT);
   localparam logic [W:0] LP_HI_C  = (W+1)'(LEFT + PADDLE_W - 1);

   // One extra bit on every operand keeps the sums below from wrapping.
   logic [W:0] bx_s, by_s, bx_end_s, by_end_s;
   logic [W:0] pr_top_s, pr_bot_s, pl_top_s, pl_bot_s;
   logic [W:0] pad_top_s, off_s;
   logic       r_hit_s, l_hit_s;
   logic [2:0] code_s;
   logic [ZW-1:0] zone_s;

   assign bx_s     = {1'b0, ball_x_i};
   assign by_s     = {1'b0, ball_y_i};
   assign bx_end_s = bx_s + BS_C;
   assign by_end_s = by_s + BS_C;
   assign pr_top_s = {1'b0, paddle_r_y_i};
   assign pr_bot_s = pr_top_s + PLEN_C;
   assign pl_top_s = {1'b0, paddle_l_y_i};
   assign pl_bot_s = pl_top_s + PLEN_C;

   assign r_hit_s = (bx_end_s > RP_LO_C) && (bx_s <= RP_HI_C) &&
                    (by_end_s >= pr_top_s) && (by_s <= pr_bot_s);
   assign l_hit_s = (PLAYERS == 2) &&
                    (bx_end_s > LP_LO_C) && (bx_s <= LP_HI_C) &&
                    (by_end_s >= pl_top_s) && (by_s <= pl_bot_s);

   // Priority classification: misses first, then paddles, then walls.
   always_comb begin
      code_s = COL_NONE;
      if (bx_s < LEFT_C) begin
         code_s = COL_LMISS;
      end else if (bx_s >= RIGHT_C) begin
         code_s = COL_RMISS;
      end else if (r_hit_s) begin
         code_s = COL_RPADDLE;
      end else if (l_hit_s) begin
         code_s = COL_LPADDLE;
      end else if (by_s <= TOP_C) begin
         code_s = COL_CEILING;
      end else if (by_end_s >= BOTTOM_C) begin
         code_s = COL_FLOOR;
      end else begin
         code_s = COL_NONE;
      end
   end

   assign pad_top_s = (code_s == COL_LPADDLE) ? pl_top_s : pr_top_s;
   assign off_s     = (by_end_s >= pad_top_s) ? (by_end_s - pad_top_s) : '0;

   // Thermometer of constant thresholds k*SEG gives min(ZONES-1, off/SEG).
   always_comb begin
      zone_s = '0;
      if ((code_s == COL_RPADDLE) || (code_s == COL_LPADDLE)) begin
         for (int k = 1; k < ZONES; k++) begin
            zone_s = (off_s >= (W+1)'(k * SEG)) ? ZW'(k) : zone_s;
         end
      end else begin
         zone_s = '0;
      end
   end

   assign code_o = code_s;
   assign zone_o = zone_s;

endmodule

// File: rtl/ball_collision_gen2.sv
// Pong collision event generator: registers classified collisions into
// one-shot ColValid events with a holdoff window and a latched miss state.
module ball_collision_gen2
   import ball_collision_gen2_pkg::*;
#(
   parameter int W          = 10,
   parameter int BALL_SIZE  = 8,
   parameter int PADDLE_LEN = 80,
   parameter int TOP        = 73,
   parameter int BOTTOM     = 472,
   parameter int LEFT       = 8,
   parameter int RIGHT      = 600,
   parameter int PADDLE_W   = 8,
   parameter int PLAYERS    = 1,
   parameter int HOLDOFF    = 4,
   parameter int ZONES      = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       GameEnable,
   input  logic                       ballPosReset,
   input  logic [W-1:0]               ballPosX,
   input  logic [W-1:0]               ballPosY,
   input  logic [W-1:0]               paddleRPosY,
   input  logic [W-1:0]               paddleLPosY,
   output logic [2:0]                 ColOut,
   output logic                       ColValid,
   output logic [$clog2(ZONES)-1:0]   HitZone,
   output logic                       Scored
);

   localparam int ZW    = $clog2(ZONES);
   localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLDOFF);

   logic [2:0]       class_code_s;
   logic [ZW-1:0]    class_zone_s;

   state_e           state_q, state_d;
   logic [2:0]       col_q, col_d;
   logic [ZW-1:0]    zone_q, zone_d;
   logic             valid_q, valid_d;
   logic             scored_q, scored_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   collision_classifier #(
      .W          (W),
      .BALL_SIZE  (BALL_SIZE),
      .PADDLE_LEN (PADDLE_LEN),
      .TOP        (TOP),
      .BOTTOM     (BOTTOM),
      .LEFT       (LEFT),
      .RIGHT      (RIGHT),
      .PADDLE_W   (PADDLE_W),
      .PLAYERS    (PLAYERS),
      .ZONES      (ZONES)
   ) u_classifier (
      .ball_x_i     (ballPosX),
      .ball_y_i     (ballPosY),
      .paddle_r_y_i (paddleRPosY),
      .paddle_l_y_i (paddleLPosY),
      .code_o       (class_code_s),
      .zone_o       (class_zone_s)
   );

   // Next-state and output logic; with GameEnable low everything holds and ColValid drops.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      zone_d  = zone_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      if (GameEnable) begin
         case (state_q)
            ST_ARMED: begin
               if (class_code_s != COL_NONE) begin
                  col_d   = class_code_s;
                  zone_d  = class_zone_s;
                  valid_d = 1'b1;
                  cnt_d   = CNT_W'(1);
                  state_d = is_miss(class_code_s) ? ST_SCORED : ST_HOLD;
               end else begin
                  cnt_d   = '0;
               end
            end
            ST_HOLD: begin
               if (is_miss(class_code_s)) begin
                  col_d   = class_code_s;
                  zone_d  = class_zone_s;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_SCORED;
               end else if ((cnt_q >= HOLD_C) && (class_code_s == COL_NONE)) begin
                  col_d   = COL_NONE;
                  zone_d  = '0;
                  cnt_d   = '0;
                  state_d = ST_ARMED;
               end else begin
                  cnt_d   = (cnt_q < HOLD_C) ? (cnt_q + CNT_W'(1)) : cnt_q;
               end
            end
            ST_SCORED: begin
               state_d = ST_SCORED;
            end
            default: begin
               state_d = ST_ARMED;
               col_d   = COL_NONE;
               zone_d  = '0;
               cnt_d   = '0;
            end
         endcase
      end else begin
         valid_d = 1'b0;
      end
      scored_d = (state_d == ST_SCORED);
   end

   // State and output registers; round restart clears exactly like Reset.
   always_ff @(posedge Clk) begin
      if (Reset || ballPosReset) begin
         state_q  <= ST_ARMED;
         col_q    <= COL_NONE;
         zone_q   <= '0;
         valid_q  <= 1'b0;
         scored_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         zone_q   <= zone_d;
         valid_q  <= valid_d;
         scored_q <= scored_d;
         cnt_q    <= cnt_d;
      end
   end

   assign ColOut   = col_q;
   assign ColValid = valid_q;
   assign HitZone  = zone_q;
   assign Scored   = scored_q;

endmodule

// File: tb/tb_ball_collision_gen2.sv
// Directed bench for ball_collision_gen2: a one-player and a two-player
// instance share stimulus; expected values are hand-computed per scenario.
module tb_ball_collision_gen2;

   logic       Clk = 1'b0;
   logic       Reset, GameEnable, ballPosReset;
   logic [9:0] ballPosX, ballPosY, paddleRPosY, paddleLPosY;
   logic [2:0] col1, col2;
   logic       valid1, valid2, scored1, scored2;
   logic [1:0] zone1, zone2;
   int         checks = 0;
   int         errors = 0;

   always #5 Clk = ~Clk;

   ball_collision_gen2 u_dut (
      .Clk(Clk), .Reset(Reset), .GameEnable(GameEnable), .ballPosReset(ballPosReset),
      .ballPosX(ballPosX), .ballPosY(ballPosY),
      .paddleRPosY(paddleRPosY), .paddleLPosY(paddleLPosY),
      .ColOut(col1), .ColValid(valid1), .HitZone(zone1), .Scored(scored1)
   );

   ball_collision_gen2 #(.PLAYERS(2)) u_dut2 (
      .Clk(Clk), .Reset(Reset), .GameEnable(GameEnable), .ballPosReset(ballPosReset),
      .ballPosX(ballPosX), .ballPosY(ballPosY),
      .paddleRPosY(paddleRPosY), .paddleLPosY(paddleLPosY),
      .ColOut(col2), .ColValid(valid2), .HitZone(zone2), .Scored(scored2)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic round_reset();
      ballPosReset = 1'b1;
      ballPosX = 10'd300;
      ballPosY = 10'd200;
      step();
      ballPosReset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; GameEnable = 1'b1; ballPosReset = 1'b0;
      ballPosX = 10'd300; ballPosY = 10'd200;
      paddleRPosY = 10'd200; paddleLPosY = 10'd290;
      step(); step();
      checks++; if (col1 !== 3'd0) begin errors++; $display("FAIL reset_colout got %0d want 0", col1); end
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid1); end
      checks++; if (zone1 !== 2'd0) begin errors++; $display("FAIL reset_zone got %0d want 0", zone1); end
      checks++; if (scored1 !== 1'b0) begin errors++; $display("FAIL reset_scored got %0b want 0", scored1); end
      Reset = 1'b0;
      step();
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", valid1); end
   endtask

   task automatic test_right_paddle();
      logic [9:0] ys [4] = '{10'd172, 10'd193, 10'd194, 10'd260};
      logic [1:0] zs [4] = '{2'd0, 2'd0, 2'd1, 2'd3};
      round_reset();
      ballPosX = 10'd592; ballPosY = 10'd200; paddleRPosY = 10'd180;
      step();
      checks++; if (col1 !== 3'd1) begin errors++; $display("FAIL rpad_colout got %0d want 1", col1); end
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL rpad_valid got %0b want 1", valid1); end
      checks++; if (zone1 !== 2'd1) begin errors++; $display("FAIL rpad_zone got %0d want 1", zone1); end
      step();
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rpad_valid_one_cycle got %0b want 0", valid1); end
      checks++; if (col1 !== 3'd1) begin errors++; $display("FAIL rpad_colout_held got %0d want 1", col1); end
      for (int i = 0; i < 4; i++) begin
         round_reset();
         ballPosX = 10'd592; ballPosY = ys[i];
         step();
         checks++;
         if (zone1 !== zs[i] || col1 !== 3'd1) begin
            errors++;
            $display("FAIL rpad_zone_y%0d got zone %0d code %0d want zone %0d code 1", ys[i], zone1, col1, zs[i]);
         end
      end
      round_reset();
      paddleRPosY = 10'd200;
   endtask

   task automatic test_ceiling_hold();
      int pulses = 0;
      round_reset();
      ballPosX = 10'd300; ballPosY = 10'd73;
      for (int i = 0; i < 10; i++) begin
         step();
         if (valid1 === 1'b1) pulses++;
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL ceil_pulses got %0d want 1", pulses); end
      checks++; if (col1 !== 3'd3) begin errors++; $display("FAIL ceil_colout got %0d want 3", col1); end
      checks++; if (scored1 !== 1'b0) begin errors++; $display("FAIL ceil_scored got %0b want 0", scored1); end
   endtask

   task automatic test_hold_release();
      round_reset();
      ballPosX = 10'd300; ballPosY = 10'd73;
      step();
      checks++; if (col1 !== 3'd3 || valid1 !== 1'b1) begin errors++; $display("FAIL rel_pulse got code %0d valid %0b want 3 1", col1, valid1); end
      step();
      ballPosY = 10'd200;
      step();
      checks++; if (col1 !== 3'd3) begin errors++; $display("FAIL rel_cycle3 got %0d want 3", col1); end
      step();
      checks++; if (col1 !== 3'd3) begin errors++; $display("FAIL rel_cycle4 got %0d want 3", col1); end
      step();
      checks++; if (col1 !== 3'd0) begin errors++; $display("FAIL rel_cycle5 got %0d want 0", col1); end
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rel_valid got %0b want 0", valid1); end
   endtask

   task automatic test_miss();
      int pulses = 0;
      round_reset();
      ballPosX = 10'd600; ballPosY = 10'd200;
      step();
      checks++; if (col1 !== 3'd4 || valid1 !== 1'b1) begin errors++; $display("FAIL miss_event got code %0d valid %0b want 4 1", col1, valid1); end
      checks++; if (scored1 !== 1'b1) begin errors++; $display("FAIL miss_scored got %0b want 1", scored1); end
      for (int i = 0; i < 5; i++) begin
         step();
         if (valid1 === 1'b1) pulses++;
      end
      checks++; if (pulses != 0 || col1 !== 3'd4) begin errors++; $display("FAIL miss_held got pulses %0d code %0d want 0 4", pulses, col1); end
      ballPosReset = 1'b1; ballPosX = 10'd300;
      step();
      ballPosReset = 1'b0;
      checks++; if (col1 !== 3'd0 || scored1 !== 1'b0) begin errors++; $display("FAIL miss_restart got code %0d scored %0b want 0 0", col1, scored1); end
   endtask

   task automatic test_wall_ceiling();
      round_reset();
      ballPosX = 10'd4; ballPosY = 10'd73;
      step();
      checks++; if (col1 !== 3'd5) begin errors++; $display("FAIL wall_ceil got %0d want 5", col1); end
      round_reset();
   endtask

   task automatic test_miss_preempt();
      round_reset();
      ballPosX = 10'd300; ballPosY = 10'd73;
      step(); step();
      ballPosX = 10'd4; ballPosY = 10'd200;
      step();
      checks++; if (col1 !== 3'd5 || valid1 !== 1'b1) begin errors++; $display("FAIL preempt got code %0d valid %0b want 5 1", col1, valid1); end
      checks++; if (scored1 !== 1'b1) begin errors++; $display("FAIL preempt_scored got %0b want 1", scored1); end
      round_reset();
   endtask

   task automatic test_left_paddle();
      round_reset();
      ballPosX = 10'd10; ballPosY = 10'd300; paddleLPosY = 10'd290;
      step();
      checks++; if (col2 !== 3'd6 || valid2 !== 1'b1) begin errors++; $display("FAIL lpad_p2 got code %0d valid %0b want 6 1", col2, valid2); end
      checks++; if (zone2 !== 2'd0) begin errors++; $display("FAIL lpad_p2_zone got %0d want 0", zone2); end
      checks++; if (col1 !== 3'd0 || valid1 !== 1'b0) begin errors++; $display("FAIL lpad_p1 got code %0d valid %0b want 0 0", col1, valid1); end
      round_reset();
   endtask

   task automatic test_freeze();
      int pulses = 0;
      round_reset();
      GameEnable = 1'b0;
      ballPosX = 10'd300; ballPosY = 10'd73;
      for (int i = 0; i < 3; i++) begin
         step();
         if (valid1 === 1'b1) pulses++;
      end
      checks++; if (pulses != 0 || col1 !== 3'd0) begin errors++; $display("FAIL freeze_idle got pulses %0d code %0d want 0 0", pulses, col1); end
      GameEnable = 1'b1;
      step();
      checks++; if (col1 !== 3'd3 || valid1 !== 1'b1) begin errors++; $display("FAIL freeze_enable got code %0d valid %0b want 3 1", col1, valid1); end
      GameEnable = 1'b0;
      ballPosY = 10'd200;
      for (int i = 0; i < 6; i++) step();
      checks++; if (col1 !== 3'd3 || valid1 !== 1'b0) begin errors++; $display("FAIL freeze_hold got code %0d valid %0b want 3 0", col1, valid1); end
      GameEnable = 1'b1;
      step(); step(); step();
      checks++; if (col1 !== 3'd3) begin errors++; $display("FAIL freeze_counter got %0d want 3", col1); end
      step();
      checks++; if (col1 !== 3'd0) begin errors++; $display("FAIL freeze_release got %0d want 0", col1); end
   endtask

   task automatic test_reset_mid_hold();
      round_reset();
      ballPosX = 10'd592; ballPosY = 10'd200; paddleRPosY = 10'd180;
      step(); step();
      Reset = 1'b1;
      step();
      checks++;
      if (col1 !== 3'd0 || valid1 !== 1'b0 || zone1 !== 2'd0 || scored1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hold got code %0d valid %0b zone %0d scored %0b want all 0", col1, valid1, zone1, scored1);
      end
      Reset = 1'b0;
      ballPosX = 10'd300;
      paddleRPosY = 10'd200;
      step();
   endtask

   initial begin
      test_reset();
      test_right_paddle();
      test_ceiling_hold();
      test_hold_release();
      test_miss();
      test_wall_ceiling();
      test_miss_preempt();
      test_left_paddle();
      test_freeze();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
